// File: rtl/fifo2_tx_rx.sv
// Command/report bridge between a host FIFO pair and one SL transmitter and receiver.
// Commands are popped, decoded onto the selected channel, and reports pushed back.
module fifo2_tx_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_read_empty,
  input  logic [33:0] fifo_read_data,
  output logic        fifo_read_inc,
  input  logic        fifo_write_full,
  output logic [33:0] fifo_write_data,
  output logic        fifo_write_inc,
  output logic [31:0] wr_data_tx,
  output logic        data_we_tx,
  output logic [15:0] wr_config_tx,
  output logic        config_we_tx,
  input  logic        rd_status_tx,
  input  logic [15:0] rd_config_tx,
  input  logic        status_changed_tx,
  output logic [15:0] wr_config_rx,
  output logic        config_we_rx,
  input  logic [31:0] rd_data_rx,
  input  logic [15:0] rd_status_rx,
  input  logic [15:0] rd_config_rx,
  input  logic        data_status_changed_rx,
  output logic        word_picked_rx
);

  typedef enum logic [2:0] {
    IDLE, ACK, ECHO, TX_STAT, TX_CFG, RX_DATA, RX_STAT, RX_CFG
  } state_t;

  state_t     state;
  logic       channel;
  logic       pend_rx;
  logic       pend_tx;
  logic       rx_evt;
  logic       tx_evt;
  logic [1:0] cmd_type;

  assign cmd_type = fifo_read_data[33:32];
  assign rx_evt   = pend_rx | data_status_changed_rx;
  assign tx_evt   = pend_tx | status_changed_tx;

  // Pending flags clear when their word is pushed, so events already covered by a running report merge into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      channel         <= 1'b0;
      pend_rx         <= 1'b0;
      pend_tx         <= 1'b0;
      fifo_read_inc   <= 1'b0;
      fifo_write_inc  <= 1'b0;
      fifo_write_data <= 34'd0;
      wr_data_tx      <= 32'd0;
      data_we_tx      <= 1'b0;
      wr_config_tx    <= 16'd0;
      config_we_tx    <= 1'b0;
      wr_config_rx    <= 16'd0;
      config_we_rx    <= 1'b0;
      word_picked_rx  <= 1'b0;
    end else begin
      fifo_read_inc  <= 1'b0;
      fifo_write_inc <= 1'b0;
      data_we_tx     <= 1'b0;
      config_we_tx   <= 1'b0;
      config_we_rx   <= 1'b0;
      word_picked_rx <= 1'b0;
      if (data_status_changed_rx) pend_rx <= 1'b1;
      if (status_changed_tx)      pend_tx <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_evt) begin
            if (!fifo_write_full) begin
              fifo_write_inc  <= 1'b1;
              fifo_write_data <= {2'b01, rd_data_rx};
              word_picked_rx  <= 1'b1;
              pend_rx         <= 1'b0;
              state           <= RX_STAT;
            end
          end else if (tx_evt) begin
            if (!fifo_write_full) begin
              fifo_write_inc  <= 1'b1;
              fifo_write_data <= {2'b10, 31'd0, rd_status_tx};
              pend_tx         <= 1'b0;
            end
          end else if (!fifo_read_empty) begin
            fifo_read_inc <= 1'b1;
            state         <= ACK;
            case (cmd_type)
              2'd0: begin
                if (channel) begin
                  config_we_rx <= 1'b1;
                  wr_config_rx <= fifo_read_data[15:0];
                  state        <= RX_CFG;
                end else begin
                  config_we_tx <= 1'b1;
                  wr_config_tx <= fifo_read_data[15:0];
                  state        <= TX_CFG;
                end
              end
              2'd1: begin
                if (!channel) begin
                  data_we_tx <= 1'b1;
                  wr_data_tx <= fifo_read_data[31:0];
                end
              end
              2'd3: begin
                channel <= fifo_read_data[0];
                state   <= ECHO;
              end
              default: state <= ACK;
            endcase
          end
        end
        ACK: state <= IDLE;
        ECHO: begin
          if (!fifo_write_full) begin
            fifo_write_inc  <= 1'b1;
            fifo_write_data <= {2'b11, 31'd0, channel};
            state           <= channel ? RX_DATA : TX_STAT;
          end
        end
        TX_STAT: begin
          if (!fifo_write_full) begin
            fifo_write_inc  <= 1'b1;
            fifo_write_data <= {2'b10, 31'd0, rd_status_tx};
            pend_tx         <= 1'b0;
            state           <= TX_CFG;
          end
        end
        TX_CFG: begin
          if (!fifo_write_full) begin
            fifo_write_inc  <= 1'b1;
            fifo_write_data <= {2'b00, 16'd0, rd_config_tx};
            state           <= IDLE;
          end
        end
        RX_DATA: begin
          if (!fifo_write_full) begin
            fifo_write_inc  <= 1'b1;
            fifo_write_data <= {2'b01, rd_data_rx};
            word_picked_rx  <= 1'b1;
            pend_rx         <= 1'b0;
            state           <= RX_STAT;
          end
        end
        RX_STAT: begin
          if (!fifo_write_full) begin
            fifo_write_inc  <= 1'b1;
            fifo_write_data <= {2'b10, 16'd0, rd_status_rx};
            state           <= RX_CFG;
          end
        end
        RX_CFG: begin
          if (!fifo_write_full) begin
            fifo_write_inc  <= 1'b1;
            fifo_write_data <= {2'b00, 16'd0, rd_config_rx};
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo2_tx_rx.sv
// Directed and randomized bench for fifo2_tx_rx; pushed words are collected and
// compared against a queue of expected reports built from the command rules.
module tb_fifo2_tx_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_read_empty;
  logic [33:0] fifo_read_data;
  logic        fifo_read_inc;
  logic        fifo_write_full;
  logic [33:0] fifo_write_data;
  logic        fifo_write_inc;
  logic [31:0] wr_data_tx;
  logic        data_we_tx;
  logic [15:0] wr_config_tx;
  logic        config_we_tx;
  logic        rd_status_tx;
  logic [15:0] rd_config_tx;
  logic        status_changed_tx;
  logic [15:0] wr_config_rx;
  logic        config_we_rx;
  logic [31:0] rd_data_rx;
  logic [15:0] rd_status_rx;
  logic [15:0] rd_config_rx;
  logic        data_status_changed_rx;
  logic        word_picked_rx;

  fifo2_tx_rx dut (
    .clk(clk), .rst(rst),
    .fifo_read_empty(fifo_read_empty), .fifo_read_data(fifo_read_data), .fifo_read_inc(fifo_read_inc),
    .fifo_write_full(fifo_write_full), .fifo_write_data(fifo_write_data), .fifo_write_inc(fifo_write_inc),
    .wr_data_tx(wr_data_tx), .data_we_tx(data_we_tx), .wr_config_tx(wr_config_tx), .config_we_tx(config_we_tx),
    .rd_status_tx(rd_status_tx), .rd_config_tx(rd_config_tx), .status_changed_tx(status_changed_tx),
    .wr_config_rx(wr_config_rx), .config_we_rx(config_we_rx), .rd_data_rx(rd_data_rx),
    .rd_status_rx(rd_status_rx), .rd_config_rx(rd_config_rx),
    .data_status_changed_rx(data_status_changed_rx), .word_picked_rx(word_picked_rx)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          stray_pk = 0;
  int          inc_cyc;
  bit          mch;
  logic [33:0] got_q[$];
  logic        got_pk[$];
  int          got_cyc[$];
  logic [33:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every push with its picked flag and cycle stamp.
  always @(negedge clk) begin
    if (fifo_write_inc) begin
      got_q.push_back(fifo_write_data);
      got_pk.push_back(word_picked_rx);
      got_cyc.push_back(cyc);
    end else if (word_picked_rx) begin
      stray_pk++;
    end
  end

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_report(input bit ch);
    if (ch) begin
      exp_q.push_back({2'b01, rd_data_rx});
      exp_q.push_back({2'b10, 16'd0, rd_status_rx});
      exp_q.push_back({2'b00, 16'd0, rd_config_rx});
    end else begin
      exp_q.push_back({2'b10, 31'd0, rd_status_tx});
      exp_q.push_back({2'b00, 16'd0, rd_config_tx});
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] p);
    bit ok = 1'b0;
    bit cw_tx, cw_rx, dw_tx;
    cw_tx = (t == 2'd0) && !mch;
    cw_rx = (t == 2'd0) && mch;
    dw_tx = (t == 2'd1) && !mch;
    fifo_read_data  = {t, p};
    fifo_read_empty = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (fifo_read_inc) ok = 1'b1;
    end
    chk("cmd_pop", {33'd0, ok}, 34'd1);
    inc_cyc = cyc;
    chk("config_we_tx", {33'd0, config_we_tx}, {33'd0, cw_tx});
    chk("config_we_rx", {33'd0, config_we_rx}, {33'd0, cw_rx});
    chk("data_we_tx", {33'd0, data_we_tx}, {33'd0, dw_tx});
    if (cw_tx) chk("wr_config_tx", {18'd0, wr_config_tx}, {18'd0, p[15:0]});
    if (cw_rx) chk("wr_config_rx", {18'd0, wr_config_rx}, {18'd0, p[15:0]});
    if (dw_tx) chk("wr_data_tx", {2'd0, wr_data_tx}, {2'd0, p});
    fifo_read_empty = 1'b1;
    @(negedge clk);
    chk("pop_single", {33'd0, fifo_read_inc}, 34'd0);
    if (t == 2'd0) exp_q.push_back(mch ? {2'b00, 16'd0, rd_config_rx} : {2'b00, 16'd0, rd_config_tx});
    if (t == 2'd3) begin
      mch = p[0];
      exp_q.push_back({2'b11, 31'd0, mch});
      add_report(mch);
    end
  endtask

  task automatic pulse(input bit rx, input bit tx);
    data_status_changed_rx = rx;
    status_changed_tx      = tx;
    @(negedge clk);
    data_status_changed_rx = 1'b0;
    status_changed_tx      = 1'b0;
  endtask

  task automatic flush(input string tag);
    tick(14);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_word"}, got_q[i], exp_q[i]);
      chk({tag, "_picked"}, {33'd0, got_pk[i]}, {33'd0, exp_q[i][33:32] == 2'b01});
    end
    chk({tag, "_stray_pick"}, stray_pk, 34'd0);
    got_q.delete();
    got_pk.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int evt;
    rst = 1'b1;
    fifo_read_empty = 1'b1;
    fifo_read_data = 34'd0;
    fifo_write_full = 1'b0;
    rd_status_tx = 1'b0;
    rd_config_tx = 16'd0;
    status_changed_tx = 1'b0;
    rd_data_rx = 32'd0;
    rd_status_rx = 16'd0;
    rd_config_rx = 16'd0;
    data_status_changed_rx = 1'b0;
    mch = 1'b0;
    tick(3);
    chk("rst_strobes", {28'd0, fifo_read_inc, fifo_write_inc, data_we_tx, config_we_tx, config_we_rx, word_picked_rx}, 34'd0);
    chk("rst_write_data", fifo_write_data, 34'd0);
    chk("rst_wr_data_tx", {2'd0, wr_data_tx}, 34'd0);
    chk("rst_wr_configs", {2'd0, wr_config_tx, wr_config_rx}, 34'd0);
    rst = 1'b0;
    tick(2);
    chk("idle_no_pop", {33'd0, fifo_read_inc}, 34'd0);

    // Config on tx, read-back on the very next cycle.
    rd_config_tx = 16'd87;
    send(2'd0, 32'd87);
    tick(1);
    chk("cfg_push_cycle", got_cyc.size() > 0 ? got_cyc[0] : -1, inc_cyc + 1);
    flush("cfg_tx");

    send(2'd1, 32'd91);
    send(2'd2, 32'd99);
    flush("data_illegal_tx");

    // Select rx; an rx event during the echo merges into the same report.
    rd_data_rx = 32'd456791;
    rd_status_rx = 16'd76;
    rd_config_rx = 16'd1;
    send(2'd3, 32'd1);
    pulse(1'b1, 1'b0);
    flush("sel_rx");

    rd_config_rx = 16'd88;
    send(2'd0, 32'd88);
    send(2'd1, 32'd88);
    send(2'd2, 32'd17);
    flush("cfg_rx");

    rd_status_tx = 1'b1;
    rd_config_tx = 16'd88;
    send(2'd3, 32'd0);
    flush("sel_tx");

    pulse(1'b0, 1'b1);
    chk("tx_evt_next_cycle", {33'd0, fifo_write_inc}, 34'd1);
    chk("tx_evt_word", fifo_write_data, {2'b10, 31'd0, 1'b1});
    exp_q.push_back({2'b10, 31'd0, 1'b1});
    flush("tx_evt");

    // Full stall across two rx events yields exactly one report.
    fifo_write_full = 1'b1;
    pulse(1'b1, 1'b0);
    add_report(1'b1);
    tick(3);
    pulse(1'b1, 1'b0);
    tick(4);
    chk("stall_no_push", got_q.size(), 34'd0);
    fifo_write_full = 1'b0;
    flush("stall");

    // Reset while a report is frozen aborts it.
    fifo_write_full = 1'b1;
    send(2'd3, 32'd1);
    exp_q.delete();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    fifo_write_full = 1'b0;
    mch = 1'b0;
    flush("rst_abort");

    for (int k = 0; k < 30; k++) begin
      rd_data_rx   = $urandom;
      rd_status_rx = 16'($urandom);
      rd_config_rx = 16'($urandom);
      rd_config_tx = 16'($urandom);
      rd_status_tx = 1'($urandom_range(0, 1));
      send(2'($urandom_range(0, 3)), $urandom);
      flush("rand_cmd");
      evt = $urandom_range(0, 3);
      if (evt != 0) begin
        fifo_write_full = 1'($urandom_range(0, 1));
        pulse(evt[0], evt[1]);
        if (evt[0]) add_report(1'b1);
        if (evt[1]) exp_q.push_back({2'b10, 31'd0, rd_status_tx});
        tick($urandom_range(1, 5));
        fifo_write_full = 1'b0;
        flush("rand_evt");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
